// File: rtl/bcd_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed BCD scan controller.
package bcd_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int BCD_W     = 4;
    localparam int DEC_LINES = 10;

endpackage

// File: rtl/bcd_scan_ctrl_onehot_dec.sv
// BCD nibble to one-hot decimal lines; codes above 9 drive no line at all.
module bcd_onehot_dec
    import bcd_scan_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0]     bcd,
    output logic [DEC_LINES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (bcd <= BCD_W'(9)) begin
            onehot = DEC_LINES'(1) << bcd;
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Scans NUM_DIGITS BCD digits through one shared decoder, committing new
// values only at frame boundaries so a frame never mixes old and new digits.
module bcd_scan_ctrl
    import bcd_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 8
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_data,
    input  logic                          enable,
    input  logic                          err_clr,
    output logic [DEC_LINES-1:0]          dec_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done,
    output logic                          err
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);

    state_t                          state;
    logic [BCD_W*NUM_DIGITS-1:0]     active;
    logic [BCD_W*NUM_DIGITS-1:0]     shadow;
    logic                            pending;
    logic [IDX_W-1:0]                idx;
    logic [DW_W-1:0]                 dwell;
    logic [BCD_W-1:0]                nibble;
    logic [DEC_LINES-1:0]            dec;
    logic                            last_blank;
    logic                            commit;
    logic                            accept;
    logic                            scan;

    assign scan       = (state == SCAN);
    assign last_blank = (state == BLANK) && (idx == LAST_IDX);
    // enable only matters at frame boundaries, so a mid-frame drop finishes the frame
    assign commit     = enable && ((state == IDLE) || last_blank);
    assign accept     = load_valid && !pending;

    always_comb begin
        nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble = active[i*BCD_W +: BCD_W];
            end
        end
    end

    bcd_onehot_dec u_dec (
        .bcd    (nibble),
        .onehot (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            idx     <= '0;
            dwell   <= '0;
            err     <= 1'b0;
        end else begin
            if (commit && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= SCAN;
                        idx   <= '0;
                        dwell <= '0;
                    end
                end
                SCAN: begin
                    if (dwell == LAST_DWELL) begin
                        state <= BLANK;
                        dwell <= '0;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                BLANK: begin
                    if (idx != LAST_IDX) begin
                        idx   <= idx + 1'b1;
                        state <= SCAN;
                    end else begin
                        idx   <= '0;
                        state <= enable ? SCAN : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    dwell <= '0;
                end
            endcase

            // a new bad nibble outranks a simultaneous clear
            if (scan && (nibble > BCD_W'(9))) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign load_ready = !pending;
    assign digit_sel  = scan ? (NUM_DIGITS'(1) << idx) : '0;
    assign dec_out    = scan ? dec : '0;
    assign digit_idx  = idx;
    assign frame_done = last_blank;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl: stimulus queues expected scan outputs,
// a negedge monitor pops and compares whenever a digit or frame_done is shown.
module tb_bcd_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic        enable = 1'b0;
    logic        err_clr = 1'b0;
    logic [9:0]  dec_out;
    logic [3:0]  digit_sel;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        err;

    typedef struct packed {
        logic [3:0] sel;
        logic [9:0] dec;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    bcd_scan_ctrl #(.NUM_DIGITS(ND), .DWELL(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .enable     (enable),
        .err_clr    (err_clr),
        .dec_out    (dec_out),
        .digit_sel  (digit_sel),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [9:0] dec_of(input logic [3:0] n);
        return (n <= 4'd9) ? (10'd1 << n) : 10'd0;
    endfunction

    task automatic push_frame(input logic [15:0] v, input int ndig, input bit with_fd);
        for (int d = 0; d < ndig; d++)
            for (int k = 0; k < DW; k++)
                q.push_back({4'(1 << d), dec_of(v[4*d +: 4]), 2'(d), 1'b0});
        if (with_fd) q.push_back({4'b0000, 10'd0, 2'd3, 1'b1});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        chk(name, {15'd0, digit_sel, dec_out, digit_idx, frame_done}, 32'd0);
    endtask

    task automatic do_load(input logic [15:0] d);
        int n = 0;
        load_data  = d;
        load_valid = 1'b1;
        while (!load_ready && n < 200) begin
            tick();
            n++;
        end
        chk("load_wait", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_idx(input int i);
        int n = 0;
        while (!(digit_idx == 2'(i) && digit_sel != 4'd0) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idx", {30'd0, digit_idx}, i);
    endtask

    task automatic wait_fd;
        int n = 0;
        while (!frame_done && n < 100) begin
            tick();
            n++;
        end
        chk("fd_seen", {31'd0, frame_done}, 32'd1);
    endtask

    // One frame from IDLE; first_dec is the hand-computed digit-0 pattern.
    task automatic run_frame(input bit drop_mid, input logic [9:0] first_dec);
        int n;
        enable = 1'b1;
        tick();
        n = 1;
        chk("first_sel", {28'd0, digit_sel}, 32'h1);
        chk("first_dec", {22'd0, dec_out}, {22'd0, first_dec});
        if (!drop_mid) enable = 1'b0;
        while (!frame_done && n < 100) begin
            tick();
            n++;
            if (drop_mid && n == 13) enable = 1'b0;
        end
        chk("frame_len", n, 32'd36);
        enable = 1'b0;
        tick();
        check_idle("post_frame_idle");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (digit_sel != 4'd0 || frame_done)) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", {27'd0, digit_sel, frame_done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("scan_out", {15'd0, digit_sel, dec_out, digit_idx, frame_done}, {15'd0, e});
                end
            end
        end
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_idle("rst_out");
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_err", {31'd0, err}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_idle("idle_no_enable");

        // Basic frame with 1934
        do_load(16'h1934);
        chk("a_pending", {31'd0, load_ready}, 32'd0);
        push_frame(16'h1934, ND, 1'b1);
        run_frame(1'b0, 10'b0000010000);
        chk("a_committed", {31'd0, load_ready}, 32'd1);
        chk("a_err", {31'd0, err}, 32'd0);

        // Back-pressure: new value only from the next frame start
        push_frame(16'h1934, ND, 1'b1);
        push_frame(16'h0000, ND, 1'b1);
        enable = 1'b1;
        tick();
        wait_idx(1);
        do_load(16'h0000);
        chk("b_busy", {31'd0, load_ready}, 32'd0);
        load_data  = 16'h5678;
        load_valid = 1'b1;
        begin
            int n = 0;
            while (!load_ready && n < 100) begin
                tick();
                n++;
            end
        end
        chk("b_ready_at_frame", {31'd0, load_ready}, 32'd1);
        chk("b_commit_sel", {28'd0, digit_sel}, 32'h1);
        chk("b_commit_dec", {22'd0, dec_out}, 32'b0000000001);
        enable = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("b_second_held", {31'd0, load_ready}, 32'd0);
        wait_fd();
        tick();
        check_idle("b_idle");
        push_frame(16'h5678, ND, 1'b1);
        run_frame(1'b0, 10'b0100000000);

        // Invalid nibble and sticky err
        do_load(16'h00A0);
        chk("c_err_before", {31'd0, err}, 32'd0);
        push_frame(16'h00A0, ND, 1'b1);
        run_frame(1'b0, 10'b0000000001);
        chk("c_err_set", {31'd0, err}, 32'd1);
        tick();
        tick();
        chk("c_err_sticky", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("c_err_clr", {31'd0, err}, 32'd0);

        // Set beats a simultaneous clear
        push_frame(16'h00A0, ND, 1'b1);
        enable  = 1'b1;
        err_clr = 1'b1;
        tick();
        enable = 1'b0;
        wait_idx(1);
        tick();
        chk("c_set_wins", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        wait_fd();
        tick();
        err_clr = 1'b0;
        check_idle("c2_idle");

        // enable dropped in the middle of digit 1
        do_load(16'h2705);
        push_frame(16'h2705, ND, 1'b1);
        run_frame(1'b1, 10'b0000100000);
        tick();
        tick();
        check_idle("d_stays_idle");

        // Reset during digit 2 with a pending load
        push_frame(16'h2705, 2, 1'b0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_idx(1);
        do_load(16'h9999);
        chk("e_pending", {31'd0, load_ready}, 32'd0);
        wait_idx(2);
        rst_n = 1'b0;
        #1;
        check_idle("e_rst_out");
        chk("e_rst_ready", {31'd0, load_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("e_after_rst");
        push_frame(16'h0000, ND, 1'b1);
        run_frame(1'b0, 10'b0000000001);

        chk("sb_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Time-multiplexed scan controller that shares one BCD-to-decimal one-hot decoder across NUM_DIGITS digit positions. It accepts a packed BCD word through a valid/ready handshake into a shadow register and commits it only at frame boundaries, so a frame never shows a mix of old and new digits. It then walks the digit positions, each for a fixed dwell time with one blanking cycle between digits. It sits between the value producer (counter/register logic) and the 10-line decimal indicator array with per-digit enables.

## Interface
- NUM_DIGITS, 4, number of digit positions; must be at least 2.
- DWELL, 8, cycles each digit is driven; must be at least 1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  producer offers load_data.
- load_ready  out  1  shadow register is free.
- load_data  in  4*NUM_DIGITS  packed BCD; digit 0 is bits [3:0].
- enable  in  1  run scanning.
- err_clr  in  1  clears err.
- dec_out  out  10  one-hot decimal lines for the current digit.
- digit_sel  out  NUM_DIGITS  one-hot digit enable.
- digit_idx  out  $clog2(NUM_DIGITS)  current digit index.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- err  out  1  sticky flag: a non-BCD nibble (greater than 9) was displayed.

## Operation
- Registers:
  - active digits and shadow digits, each 4*NUM_DIGITS bits.
  - pending bit.
  - state.
  - idx.
  - dwell counter, $clog2(DWELL) bits wide (minimum 1).
- load_ready equals not pending. An accept is load_valid and load_ready: shadow takes load_data and pending is set.
- Commit: on entering SCAN with idx 0, if pending is set, active takes shadow and pending clears. A load accepted on that same edge lands in shadow and waits for the next frame.
- States and transitions:
  - IDLE:
    - Outputs are zero.
    - If enable is 1, commit and go to SCAN with idx 0 and dwell count 0.
  - SCAN:
    - digit_sel equals 1 shifted left by idx.
    - dec_out is the decode of active nibble idx: bit n is set for value n, and the output is all zeros for values 10 to 15.
    - The dwell counter increments each cycle. When it reaches DWELL-1, go to BLANK.
  - BLANK (one cycle):
    - digit_sel and dec_out are 0.
    - If idx is below NUM_DIGITS-1: idx increments, then go to SCAN.
    - Otherwise: frame_done is 1 this cycle and idx wraps to 0. If enable is 1, commit and go to SCAN; else go to IDLE.
- enable is sampled only in IDLE and in the final BLANK. Dropping enable mid-frame finishes the current frame.
- err sets on any SCAN cycle whose nibble is greater than 9. err_clr clears it. If both happen in the same cycle, set wins.
- digit_idx equals idx in every state; it is 0 in IDLE.

## Timing
- Reset values:
  - All outputs are 0, except load_ready, which is 1.
  - State is IDLE; active, shadow, idx, dwell counter and pending are all 0.
- Outputs are decoded combinationally from registered state. They change only after clock edges and are glitch-free with respect to inputs.
- Latency from enable=1 sampled in IDLE to the first driven digit is 1 edge.
- Frame length is NUM_DIGITS*(DWELL+1) cycles; with the defaults, 36.
- Asserting reset mid-frame returns to IDLE immediately and discards pending data.

## Structure
- Shared package holds:
  - the state enum: IDLE, SCAN, BLANK;
  - the BCD digit width constant, 4;
  - the decimal line count constant, 10.
- One sub-module, bcd_onehot_dec: combinational 4-bit to 10-bit one-hot decoder that outputs zero for inputs above 9. It is instantiated once and fed the nibble muxed by idx.

## Test plan
- Reset: hold rst_n=0 → all outputs 0 and load_ready=1. Release with enable=0 → state stays IDLE.
- Load 16'h1934, then set enable=1 with defaults:
  - idx 0: digit_sel=0001 and dec_out=10'b0000010000 for 8 cycles, then one blank cycle.
  - idx 1: dec_out=bit3.
  - idx 2: dec_out=bit9.
  - idx 3: dec_out=bit1.
  - frame_done pulses at cycle 36.
- Back-pressure: load 16'h0000 mid-frame, then a second load → load_ready=0 until the next frame start. The new value appears only from the next idx 0.
- Invalid nibble: load 16'h00A0 → digit 1 shows dec_out=0, err=1 and stays set. err_clr=1 for one cycle → err=0.
- enable dropped at the midpoint of digit 1 → the frame completes, frame_done pulses, and the state returns to IDLE with all outputs 0.
- Reset asserted during SCAN of digit 2 with pending=1 → outputs are 0 immediately, and load_ready=1 after reset.
